// File: rtl/q_max_reader.sv
// Purpose : sweeps all N_ACT action entries of one state in the action RAM and
//           returns the arg-max action and its signed Q-value.
// Latency : done pulses in the cycle after edge E0+N_ACT+1 (E0 = accepting edge).
// Backpressure: none; start is only honoured in IDLE, ignored otherwise (not queued).
//
// Ports:
//   clk, rst           clock, async active-high reset
//   start, state_in    request pulse and state index (latched on accept)
//   busy, done         in-progress flag, one-cycle completion pulse
//   best_action        arg-max action index (holds until next done)
//   max_value          signed maximum Q-value (holds until next done)
//   ram_en, ram_write_en, ram_rd_addr, ram_rd_data   RAM read port (1-cycle latency)
module q_max_reader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16,
  parameter int ACT_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-ACT_W-1:0] state_in,
  output logic                    busy,
  output logic                    done,
  output logic [ACT_W-1:0]        best_action,
  output logic [DATA_W-1:0]       max_value,
  output logic                    ram_en,
  output logic                    ram_write_en,
  output logic [ADDR_W-1:0]       ram_rd_addr,
  input  logic [DATA_W-1:0]       ram_rd_data
);

  localparam int ST_W = ADDR_W - ACT_W;
  localparam logic [ACT_W-1:0] ACT_LAST = {ACT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } fsm_t;

  fsm_t              fsm_q, fsm_d;
  logic [ST_W-1:0]   st_q, st_d;
  logic [ACT_W-1:0]  cnt_q, cnt_d;

  // Compare pipeline: valid flag and action index delayed to line up with RAM data.
  logic              rd_vld_q;
  logic [ACT_W-1:0]  rd_act_q;
  logic [DATA_W-1:0] run_max_q;
  logic [ACT_W-1:0]  run_act_q;
  logic [ACT_W-1:0]  best_act_q;
  logic [DATA_W-1:0] max_val_q;

  logic              take_new;
  logic [DATA_W-1:0] cand_max;
  logic [ACT_W-1:0]  cand_act;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= S_IDLE;
      st_q  <= '0;
      cnt_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    st_d  = st_q;
    cnt_d = cnt_q;
    case (fsm_q)
      S_IDLE: begin
        if (start) begin
          st_d  = state_in;
          cnt_d = '0;
          fsm_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Counter wraps within ACT_W bits, so the address never leaves the state.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ACT_LAST) begin
          fsm_d = S_DRAIN;
        end
      end
      S_DRAIN: fsm_d = S_DONE;
      S_DONE:  fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  assign ram_en       = (fsm_q == S_ISSUE);
  assign ram_write_en = 1'b0;
  assign ram_rd_addr  = ram_en ? {st_q, cnt_q} : '0;
  assign busy         = (fsm_q == S_ISSUE) || (fsm_q == S_DRAIN);
  assign done         = (fsm_q == S_DONE);

  // ---------------- compare pipeline ----------------
  // Action 0 seeds the running max; later entries win only when strictly
  // greater, so ties resolve to the lower index.
  assign take_new = (rd_act_q == '0) ||
                    ($signed(ram_rd_data) > $signed(run_max_q));
  assign cand_max = take_new ? ram_rd_data : run_max_q;
  assign cand_act = take_new ? rd_act_q    : run_act_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_q   <= 1'b0;
      rd_act_q   <= '0;
      run_max_q  <= '0;
      run_act_q  <= '0;
      best_act_q <= '0;
      max_val_q  <= '0;
    end else begin
      rd_vld_q <= ram_en;
      if (ram_en) begin
        rd_act_q <= cnt_q;
      end
      if (rd_vld_q) begin
        run_max_q <= cand_max;
        run_act_q <= cand_act;
        // The last word is consumed on the edge the RAM first sees en=0,
        // so its subsequent data clear never reaches this compare.
        if (rd_act_q == ACT_LAST) begin
          best_act_q <= cand_act;
          max_val_q  <= cand_max;
        end
      end
    end
  end

  assign best_action = best_act_q;
  assign max_value   = max_val_q;

endmodule

// File: tb/tb_q_max_reader.sv
module tb_q_max_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  state_in;
  logic        busy;
  logic        done;
  logic [1:0]  best_action;
  logic [15:0] max_value;
  logic        ram_en;
  logic        ram_write_en;
  logic [5:0]  ram_rd_addr;
  logic [15:0] ram_rd_data;

  logic [15:0] mem [64];

  int n_cmp = 0;
  int n_err = 0;

  q_max_reader #(.ADDR_W(6), .DATA_W(16), .ACT_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .state_in    (state_in),
    .busy        (busy),
    .done        (done),
    .best_action (best_action),
    .max_value   (max_value),
    .ram_en      (ram_en),
    .ram_write_en(ram_write_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data)
  );

  always #5 clk = ~clk;

  // Registered-read RAM model; output clears when not enabled.
  always @(posedge clk) begin
    if (ram_en) ram_rd_data <= mem[ram_rd_addr];
    else        ram_rd_data <= 16'h0000;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full request. Cycle i = i-th falling edge after the accepting edge E0.
  // dup=1 also pulses start across E0+2 (other state) and across the done cycle.
  task automatic sweep(input logic [3:0] st, input logic [1:0] exp_act,
                       input logic [15:0] exp_val, input bit dup);
    int          en_cnt    = 0;
    int          done_cnt  = 0;
    int          done_at   = 0;
    int          bad_addr  = 0;
    int          late_busy = 0;
    int          wr_seen   = 0;
    logic        busy1     = 1'b0;
    logic        busy5     = 1'b0;
    logic [1:0]  act_seen  = 2'd0;
    logic [15:0] val_seen  = 16'd0;
    logic [5:0]  exp_addr;
    @(negedge clk);
    start    = 1'b1;
    state_in = st;
    @(posedge clk);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (dup && i == 2) begin start = 1'b1; state_in = st + 4'd1; end
      if (dup && i == 3) start = 1'b0;
      if (dup && i == 6) begin start = 1'b1; state_in = st + 4'd1; end
      if (dup && i == 7) start = 1'b0;
      exp_addr = {st, 2'b00} + 6'(i - 1);
      if (ram_en) begin
        en_cnt++;
        if (i > 4 || ram_rd_addr !== exp_addr) bad_addr++;
      end
      if (ram_write_en !== 1'b0) wr_seen++;
      if (done) begin
        done_cnt++;
        done_at  = i;
        act_seen = best_action;
        val_seen = max_value;
      end
      if (i == 1) busy1 = busy;
      if (i == 5) busy5 = busy;
      if (i >= 6 && busy) late_busy++;
    end
    check($sformatf("st%0d_en_cycles", st), 32'(en_cnt), 32'd4);
    check($sformatf("st%0d_addr_errs", st), 32'(bad_addr), 32'd0);
    check($sformatf("st%0d_write_en", st), 32'(wr_seen), 32'd0);
    check($sformatf("st%0d_done_cycle", st), 32'(done_at), 32'd6);
    check($sformatf("st%0d_done_count", st), 32'(done_cnt), 32'd1);
    check($sformatf("st%0d_best_action", st), 32'(act_seen), 32'(exp_act));
    check($sformatf("st%0d_max_value", st), 32'(val_seen), 32'(exp_val));
    check($sformatf("st%0d_busy_first", st), 32'(busy1), 32'd1);
    check($sformatf("st%0d_busy_last", st), 32'(busy5), 32'd1);
    check($sformatf("st%0d_busy_after", st), 32'(late_busy), 32'd0);
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_busy"}, 32'(busy), 32'd0);
    check({pfx, "_done"}, 32'(done), 32'd0);
    check({pfx, "_ram_en"}, 32'(ram_en), 32'd0);
    check({pfx, "_ram_addr"}, 32'(ram_rd_addr), 32'd0);
    check({pfx, "_best_action"}, 32'(best_action), 32'd0);
    check({pfx, "_max_value"}, 32'(max_value), 32'd0);
  endtask

  initial begin
    int done_hold;
    rst      = 1'b0;
    start    = 1'b0;
    state_in = 4'd0;
    for (int a = 0; a < 64; a++) mem[a] = 16'h0000;
    // state 5: 10, 300, -7, 299
    mem[20] = 16'd10;   mem[21] = 16'd300;  mem[22] = 16'hFFF9; mem[23] = 16'd299;
    // state 0: -5, -5, -100, -6
    mem[0]  = 16'hFFFB; mem[1]  = 16'hFFFB; mem[2]  = 16'hFF9C; mem[3]  = 16'hFFFA;
    // state 7: all 0x7FFF
    mem[28] = 16'h7FFF; mem[29] = 16'h7FFF; mem[30] = 16'h7FFF; mem[31] = 16'h7FFF;
    // state 15: 0x8000 x3, 1
    mem[60] = 16'h8000; mem[61] = 16'h8000; mem[62] = 16'h8000; mem[63] = 16'd1;
    // state 9: 1,2,3,4 ; state 10 (must not be used): large values
    mem[36] = 16'd1;    mem[37] = 16'd2;    mem[38] = 16'd3;    mem[39] = 16'd4;
    mem[40] = 16'd1000; mem[41] = 16'd2000; mem[42] = 16'd3000; mem[43] = 16'd4000;
    // state 6 (aborted sweep)
    mem[24] = 16'd77;   mem[25] = 16'd88;   mem[26] = 16'd99;   mem[27] = 16'd11;
    // state 2: 0, -1, 50, 50
    mem[8]  = 16'd0;    mem[9]  = 16'hFFFF; mem[10] = 16'd50;   mem[11] = 16'd50;

    // Asynchronous reset mid-cycle, held for 3 cycles.
    #2 rst = 1'b1;
    #1 check_zero_outputs("rst0");
    done_hold = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_hold++;
    end
    check("rst0_done_during_hold", 32'(done_hold), 32'd0);
    rst = 1'b0;

    sweep(4'd5,  2'd1, 16'd300,  1'b0);
    sweep(4'd0,  2'd0, 16'hFFFB, 1'b0);
    sweep(4'd7,  2'd0, 16'h7FFF, 1'b0);
    sweep(4'd15, 2'd3, 16'd1,    1'b0);
    sweep(4'd9,  2'd3, 16'd4,    1'b1);

    // Reset during a sweep of state 6 at E0+2; outputs hold 3/4 beforehand.
    @(negedge clk);
    start    = 1'b1;
    state_in = 4'd6;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("abort_busy_before_rst", 32'(busy), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero_outputs("rst1");
    done_hold = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_hold++;
    end
    check("rst1_done_during_hold", 32'(done_hold), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst1_best_after_release", 32'(best_action), 32'd0);
    check("rst1_max_after_release", 32'(max_value), 32'd0);
    sweep(4'd2, 2'd2, 16'd50, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/q_max_reader.md
Name: q_max_reader

Overview:
- Read-side controller for the 64x16 action RAM.
- On request, sweeps every action entry of one state and returns the action with the largest Q-value, plus that value.
- Sits between the agent FSM (start/done handshake) and the RAM read port: it drives the RAM enable and read address and consumes the RAM data output.
- Used by both action selection (greedy policy) and the max-Q term of the Q-update.

Parameters:
ADDR_W, 6, RAM address width; RAM address = {state, action}
DATA_W, 16, Q-value width, signed two's complement
ACT_W, 2, action index width; N_ACT = 2**ACT_W actions per state

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
state_in  input  ADDR_W-ACT_W  state index; latched when start is accepted
busy  output  1  high from acceptance until the cycle before done
done  output  1  one-cycle pulse; results valid in the same cycle
best_action  output  ACT_W  index of the maximum entry
max_value  output  DATA_W  maximum Q-value (signed)
ram_en  output  1  RAM enable; high only while addresses are issued
ram_write_en  output  1  constant 0 (read-only master)
ram_rd_addr  output  ADDR_W  RAM read address
ram_rd_data  input  DATA_W  RAM registered read data (1-cycle latency)

Behaviour:
- Reset (async, immediate): state=IDLE; busy=0, done=0, ram_en=0, ram_rd_addr=0, best_action=0, max_value=0; any pipeline valid flag cleared.
- Reset mid-sweep aborts the operation with no done pulse. The next start after reset release behaves normally.
- States:
  - IDLE: on start=1 at edge E0, latch state_in, go to ISSUE, action counter=0.
  - ISSUE: ram_en=1, ram_rd_addr={state_q, cnt}; cnt increments each edge. After the edge issuing cnt=N_ACT-1, go to DRAIN, ram_en=0.
  - DRAIN: one cycle to consume the last data word, then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Issue schedule: address for action k is driven in the cycle after edge E0+k and sampled by the RAM at edge E0+k+1. The corresponding data is valid on ram_rd_data after that edge.
- Compare pipeline: a 1-cycle-delayed valid flag tracks each issued read. At each edge where it is set, the incoming data is compared against the running max.
  - First entry (action 0) is loaded unconditionally.
  - Later entries replace the max only if strictly greater (signed compare).
  - Ties keep the lower action index.
  - best_action is taken from a delayed copy of the issue counter.
- Latency: done is high in the cycle following edge E0+N_ACT+1 (N_ACT=4: 5 edges after the accepting edge). busy is high for cycles E0+1 .. E0+N_ACT+1.
- best_action and max_value update only at the final compare and hold until the next done. Intermediate running-max registers are internal.
- start during busy or done is ignored, not queued. start in the same cycle as the done pulse is also ignored.
- The RAM clears data_out when en=0. The last word is consumed at the edge the RAM first sees en=0, so the clear does not corrupt the result.
- ram_write_en is never asserted. Address arithmetic wraps naturally within ACT_W bits and never crosses into the neighbouring state.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately, ram_en=0; hold 3 cycles, no done.
- Basic max: state 5 entries (addr 20..23) = 10, 300, -7, 299; start -> addresses 20,21,22,23 on consecutive cycles; done 5 edges after accept with best_action=1, max_value=300.
- Signed compare and tie: state 0 = -5, -5, -100, -6 -> best_action=0, max_value=-5 (0xFFFB); also all entries 0x7FFF -> best_action=0.
- Boundary state and last action: state 15 (addr 60..63) = 0x8000, 0x8000, 0x8000, 1 -> best_action=3, max_value=1; ram_rd_addr never exceeds 63.
- Start while busy: pulse start at E0 and again at E0+2 with a different state_in -> exactly one done, result for the first state; ram_en high exactly 4 cycles.
- Reset mid-sweep then restart: assert rst at E0+2, release, start state 2 -> previous outputs remain 0, correct result for state 2, single done pulse.
